// File: rtl/rx_buffer_pkg.sv
// Shared constants, state encoding and sizing helpers for the UART receive-side
// word assembler that feeds the instruction-memory loader.
package rx_buffer_pkg;

   localparam int RX_WORD_WIDTH = 32;
   localparam int RX_BYTE_WIDTH = 8;
   localparam logic [RX_WORD_WIDTH-1:0] RX_HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } rx_state_e;

   // Bytes per word, and the byte-counter width that indexes them.
   function automatic int rx_bpw(input int word_w, input int byte_w);
      return word_w / byte_w;
   endfunction

   function automatic int rx_cnt_w(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

// File: rtl/rx_buffer.sv
// Assembles little-endian UART bytes into instruction words, emits each with a
// sequential write address, and stops on a HALT word or a full memory.
module rx_buffer
   import rx_buffer_pkg::*;
#(
   parameter int                            INSTRUCT_MEM_WIDTH = RX_WORD_WIDTH,
   parameter int                            BYTE_WIDTH         = RX_BYTE_WIDTH,
   parameter int                            ADDR_WIDTH         = 8,
   parameter int                            MEM_DEPTH          = 256,
   parameter logic [INSTRUCT_MEM_WIDTH-1:0] HALT_WORD          = INSTRUCT_MEM_WIDTH'(RX_HALT_WORD)
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_load_enable,
   input  logic                          i_rx_done,
   input  logic [BYTE_WIDTH-1:0]         i_rx_data,
   output logic [INSTRUCT_MEM_WIDTH-1:0] o_word,
   output logic                          o_word_valid,
   output logic [ADDR_WIDTH-1:0]         o_write_addr,
   output logic                          o_load_done,
   output logic                          o_overflow,
   output logic                          o_busy
);

   localparam int BPW   = rx_bpw(INSTRUCT_MEM_WIDTH, BYTE_WIDTH);
   localparam int CNT_W = rx_cnt_w(BPW);

   rx_state_e                     state_q, state_d;
   logic [CNT_W-1:0]              byte_cnt_q;
   logic [INSTRUCT_MEM_WIDTH-1:0] word_q, assembled;
   logic [ADDR_WIDTH-1:0]         addr_q;
   logic                          capture, discard, last_byte, is_halt, at_last_addr;

   // NOTE: every signal driven here is assigned a default first, so no path
   // through the case statement can leave a value held and infer a latch.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      discard = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_load_enable && i_rx_done) begin
               capture = 1'b1;
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // Dropping enable wins over a coincident strobe: that byte is lost.
            if (!i_load_enable) begin
               discard = 1'b1;
               state_d = ST_IDLE;
            end else if (i_rx_done) begin
               capture = 1'b1;
            end
         end
         default: ;
      endcase

      assembled = word_q;
      for (int k = 0; k < BPW; k++) begin
         if (byte_cnt_q == CNT_W'(k)) assembled[k*BYTE_WIDTH +: BYTE_WIDTH] = i_rx_data;
      end

      last_byte    = capture && (byte_cnt_q == CNT_W'(BPW - 1));
      is_halt      = (assembled == HALT_WORD);
      at_last_addr = (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1));
      if (last_byte && (is_halt || at_last_addr)) state_d = ST_DONE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         word_q       <= '0;
         addr_q       <= '0;
         o_word       <= '0;
         o_word_valid <= 1'b0;
         o_load_done  <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         state_q      <= state_d;
         o_word_valid <= last_byte;
         // The address advances at the end of the cycle in which it was shown.
         if (o_word_valid) addr_q <= addr_q + ADDR_WIDTH'(1);

         if (last_byte) begin
            o_word     <= assembled;
            word_q     <= '0;
            byte_cnt_q <= '0;
         end else if (capture) begin
            word_q     <= assembled;
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
         end else if (discard) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
         end

         if (last_byte && (is_halt || at_last_addr)) o_load_done <= 1'b1;
         if (last_byte && !is_halt && at_last_addr)  o_overflow  <= 1'b1;
      end
   end

   assign o_write_addr = addr_q;
   assign o_busy       = (byte_cnt_q != '0);

endmodule

// File: tb/tb_rx_buffer.sv
// Directed bench for rx_buffer: a default instance plus a MEM_DEPTH=4 instance
// for the memory-full path, both fed the same byte stream.
module tb_rx_buffer;

   logic        clk = 1'b0;
   logic        reset, load_enable, rx_done;
   logic [7:0]  rx_data;

   logic [31:0] word, word4;
   logic [7:0]  write_addr, write_addr4;
   logic        word_valid, load_done, overflow, busy;
   logic        word_valid4, load_done4, overflow4, busy4;

   int n_checks = 0;
   int n_pass   = 0;

   logic [39:0] mon_q[$];
   logic [39:0] mon4_q[$];
   int          base, base4;

   always #5 clk = ~clk;

   rx_buffer dut (
      .i_clk(clk), .i_reset(reset), .i_load_enable(load_enable),
      .i_rx_done(rx_done), .i_rx_data(rx_data),
      .o_word(word), .o_word_valid(word_valid), .o_write_addr(write_addr),
      .o_load_done(load_done), .o_overflow(overflow), .o_busy(busy)
   );

   rx_buffer #(.MEM_DEPTH(4)) dut4 (
      .i_clk(clk), .i_reset(reset), .i_load_enable(load_enable),
      .i_rx_done(rx_done), .i_rx_data(rx_data),
      .o_word(word4), .o_word_valid(word_valid4), .o_write_addr(write_addr4),
      .o_load_done(load_done4), .o_overflow(overflow4), .o_busy(busy4)
   );

   // Log every emitted {address, word} pair.
   always @(negedge clk) begin
      if (word_valid)  mon_q.push_back({write_addr, word});
      if (word_valid4) mon4_q.push_back({write_addr4, word4});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) strobe(w[8*k +: 8]);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      rx_done = 1'b0;
      tick();
      reset   = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      load_enable = 1'b0;
      rx_done     = 1'b0;
      rx_data     = 8'h00;
      repeat (2) tick();
      @(negedge clk);
      check("rst_word",  64'(word),       64'h0);
      check("rst_valid", 64'(word_valid), 64'h0);
      check("rst_addr",  64'(write_addr), 64'h0);
      check("rst_flags", 64'({load_done, overflow, busy}), 64'h0);
      reset = 1'b0;

      // 1: single word, one-cycle latency and one-cycle pulse
      load_enable = 1'b1;
      base = mon_q.size();
      strobe(8'h78); strobe(8'h56); strobe(8'h34);
      @(negedge clk);
      check("t1_busy_partial", 64'(busy), 64'h1);
      strobe(8'h12);
      @(negedge clk);
      check("t1_valid",  64'(word_valid), 64'h1);
      check("t1_word",   64'(word),       64'h12345678);
      check("t1_addr",   64'(write_addr), 64'h0);
      check("t1_busy",   64'(busy),       64'h0);
      @(negedge clk);
      check("t1_pulse_width", 64'(word_valid), 64'h0);
      check("t1_addr_incr",   64'(write_addr), 64'h1);
      #1;
      check("t1_pulses", 64'(mon_q.size() - base), 64'd1);

      // 2: two words on consecutive-cycle strobes
      do_reset();
      base = mon_q.size();
      send_word(32'hA1B2C3D4);
      send_word(32'h0BADF00D);
      repeat (2) @(negedge clk);
      #1;
      check("t2_pulses", 64'(mon_q.size() - base), 64'd2);
      if (mon_q.size() >= base + 2) begin
         check("t2_first",  64'(mon_q[base]),     {24'h0, 8'h00, 32'hA1B2C3D4});
         check("t2_second", 64'(mon_q[base + 1]), {24'h0, 8'h01, 32'h0BADF00D});
      end

      // 3: HALT word terminates the load, later bytes ignored
      base = mon_q.size();
      send_word(32'hFFFFFFFF);
      @(negedge clk);
      check("t3_valid",    64'(word_valid), 64'h1);
      check("t3_word",     64'(word),       64'hFFFFFFFF);
      check("t3_addr",     64'(write_addr), 64'h2);
      check("t3_done",     64'(load_done),  64'h1);
      check("t3_overflow", 64'(overflow),   64'h0);
      send_word(32'h44332211);
      repeat (2) @(negedge clk);
      #1;
      check("t3_no_more_pulses", 64'(mon_q.size() - base), 64'd1);
      check("t3_done_sticky",    64'({load_done, busy}),   64'b10);

      // 4: memory full on the depth-4 instance
      do_reset();
      base4 = mon4_q.size();
      send_word(32'h00000001);
      send_word(32'h00000002);
      send_word(32'h00000003);
      @(negedge clk);
      check("t4_done_early", 64'(load_done4), 64'h0);
      send_word(32'h00000004);
      @(negedge clk);
      check("t4_valid",     64'(word_valid4), 64'h1);
      check("t4_addr",      64'(write_addr4), 64'h3);
      check("t4_word",      64'(word4),       64'h4);
      check("t4_flags",     64'({load_done4, overflow4}), 64'b11);
      check("t4_deep_idle", 64'({load_done, overflow}),   64'b00);
      send_word(32'h00000005);
      repeat (2) @(negedge clk);
      #1;
      check("t4_pulses", 64'(mon4_q.size() - base4), 64'd4);

      // 5: enable drop discards partial word, keeps address; coincident drop with last byte
      do_reset();
      send_word(32'h01020304);
      strobe(8'h11); strobe(8'h22);
      load_enable = 1'b0;
      rx_done     = 1'b1;
      rx_data     = 8'h99;
      tick();
      rx_done = 1'b0;
      @(negedge clk);
      check("t5_busy_cleared", 64'(busy), 64'h0);
      load_enable = 1'b1;
      send_word(32'hDDCCBBAA);
      @(negedge clk);
      check("t5_word", 64'(word),       64'hDDCCBBAA);
      check("t5_addr", 64'(write_addr), 64'h1);
      #1;
      base = mon_q.size();
      strobe(8'h55); strobe(8'h66); strobe(8'h77);
      load_enable = 1'b0;
      rx_done     = 1'b1;
      rx_data     = 8'h88;
      tick();
      rx_done     = 1'b0;
      load_enable = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("t5_dropped_last", 64'(mon_q.size() - base), 64'd0);
      check("t5_busy_after",   64'(busy), 64'h0);
      send_word(32'hCAFEBABE);
      @(negedge clk);
      check("t5_resume", 64'({write_addr, word}), {24'h0, 8'h02, 32'hCAFEBABE});

      // 6: reset mid-word, then a fresh word at address 0
      do_reset();
      send_word(32'h11111111);
      strobe(8'hA0); strobe(8'hA1); strobe(8'hA2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t6_rst_outputs", 64'({word, write_addr, word_valid, load_done, overflow, busy}), 64'h0);
      send_word(32'h87654321);
      @(negedge clk);
      check("t6_fresh", 64'({word_valid, write_addr, word}), {23'h0, 1'b1, 8'h00, 32'h87654321});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
